hosc_ctrl: RTL and testbench



---
 rtl/hosc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hosc_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hosc_ctrl.sv
// ============================================================================
// Module   : hosc_ctrl
// Brief    : High-speed oscillator sequencer with shared REQ/GNT clock grants,
//            start timeout/retry, shutdown hold-off and sticky fault.
//            Optional statistics counters enabled by macro HOSC_STAT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hosc_ctrl #(
  parameter int NREQ     = 3,
  parameter int TMO_CYC  = 8,
  parameter int RETRY    = 2,
  parameter int HOLD_CYC = 4
) (
  input  logic            LCLK,
  input  logic            RST_N,
  input  logic [NREQ-1:0] REQ,
  input  logic [7:0]      CFG_HCFR,
  input  logic [3:0]      CFG_LCFR,
  input  logic            HRDY,
  input  logic            FAULT_CLR,
  output logic            HENB,
  output logic [7:0]      HCFR,
  output logic [3:0]      LCFR,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
`ifdef HOSC_STAT_CNT_EN
  output logic [7:0]      START_CNT,
  output logic [7:0]      FAIL_CNT,
`endif
  output logic            FAULT
);

  localparam int c_TMO_W  = (TMO_CYC  > 1) ? $clog2(TMO_CYC)  : 1;
  localparam int c_RTY_W  = (RETRY    > 0) ? $clog2(RETRY + 1) : 1;
  localparam int c_HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TMO_CYC - 1);
  localparam logic [c_RTY_W-1:0]  c_RTY_MAX   = c_RTY_W'(RETRY);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESTART = 3'd3,
    S_ON      = 3'd4,
    S_HOLD    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_sync1;
  logic                r_sync2;
  logic [c_TMO_W-1:0]  r_tmo_cnt;
  logic [c_RTY_W-1:0]  r_retry_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                w_req_any;
  logic                w_start_ev;

  assign w_req_any  = |REQ;
  assign w_start_ev = (r_state == S_OFF) && (w_next == S_START);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_OFF:     if (w_req_any && !FAULT) w_next = S_START;
      S_START:   w_next = S_WAIT;
      S_WAIT: begin
        // A withdrawn request abandons the start even if the oscillator just came up.
        if (!w_req_any)                 w_next = S_OFF;
        else if (r_sync2)               w_next = S_ON;
        else if (r_tmo_cnt == c_TMO_LAST)
          w_next = (r_retry_cnt < c_RTY_MAX) ? S_RESTART : S_FAULT;
      end
      S_RESTART: w_next = S_START;
      S_ON: begin
        if (!r_sync2)        w_next = S_FAULT;
        else if (!w_req_any) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (!r_sync2)                       w_next = S_FAULT;
        else if (w_req_any)                 w_next = S_ON;
        else if (r_hold_cnt == c_HOLD_LAST) w_next = S_OFF;
      end
      S_FAULT:   if (FAULT_CLR) w_next = S_OFF;
      default:   w_next = S_OFF;
    endcase
  end

  always_ff @(posedge LCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_OFF;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_tmo_cnt   <= '0;
      r_retry_cnt <= '0;
      r_hold_cnt  <= '0;
      HENB        <= 1'b0;
      HCFR        <= 8'h00;
      LCFR        <= 4'h0;
      GNT         <= '0;
      BUSY        <= 1'b0;
      FAULT       <= 1'b0;
    end else begin
      r_sync1 <= HRDY;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      LCFR    <= CFG_LCFR;
      HENB    <= (w_next == S_START) || (w_next == S_WAIT) ||
                 (w_next == S_ON)    || (w_next == S_HOLD);
      BUSY    <= (w_next != S_OFF);
      FAULT   <= (w_next == S_FAULT);
      // Grants only track requests while staying in ON; any exit drops them on the same edge.
      GNT     <= ((r_state == S_ON) && (w_next == S_ON)) ? REQ : '0;

      if (w_start_ev) begin
        HCFR        <= CFG_HCFR;
        r_retry_cnt <= '0;
      end else if (w_next == S_RESTART && r_state != S_RESTART) begin
        r_retry_cnt <= r_retry_cnt + c_RTY_W'(1);
      end

      if (r_state == S_START)
        r_tmo_cnt <= '0;
      else if (r_state == S_WAIT && r_tmo_cnt != c_TMO_LAST)
        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);

      if (r_state == S_ON)
        r_hold_cnt <= '0;
      else if (r_state == S_HOLD && r_hold_cnt != c_HOLD_LAST)
        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
    end
  end

`ifdef HOSC_STAT_CNT_EN
  logic w_fail_ev;
  assign w_fail_ev = ((w_next == S_RESTART) && (r_state != S_RESTART)) ||
                     ((w_next == S_FAULT)   && (r_state != S_FAULT));

  always_ff @(posedge LCLK or negedge RST_N) begin
    if (!RST_N) begin
      START_CNT <= 8'h00;
      FAIL_CNT  <= 8'h00;
    end else if (FAULT_CLR) begin
      START_CNT <= 8'h00;
      FAIL_CNT  <= 8'h00;
    end else begin
      if (w_start_ev && START_CNT != 8'hFF) START_CNT <= START_CNT + 8'd1;
      if (w_fail_ev  && FAIL_CNT  != 8'hFF) FAIL_CNT  <= FAIL_CNT + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hosc_ctrl.sv
// Testbench for hosc_ctrl: directed scenarios plus random traffic, scoreboarded
// against a cycle-level behavioural model of the oscillator sequencing rules.
`timescale 1ns/1ps
`default_nettype none

module tb_hosc_ctrl;
  localparam int NREQ = 3, TMO_CYC = 8, RETRY = 2, HOLD_CYC = 4;

  logic            LCLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [NREQ-1:0] REQ = '0;
  logic [7:0]      CFG_HCFR = 8'h00;
  logic [3:0]      CFG_LCFR = 4'h0;
  logic            HRDY = 1'b0;
  logic            FAULT_CLR = 1'b0;
  logic            HENB, BUSY, FAULT;
  logic [7:0]      HCFR;
  logic [3:0]      LCFR;
  logic [NREQ-1:0] GNT;
  logic [7:0]      START_CNT, FAIL_CNT;

  hosc_ctrl #(.NREQ(NREQ), .TMO_CYC(TMO_CYC), .RETRY(RETRY), .HOLD_CYC(HOLD_CYC)) dut (
    .LCLK(LCLK), .RST_N(RST_N), .REQ(REQ), .CFG_HCFR(CFG_HCFR), .CFG_LCFR(CFG_LCFR),
    .HRDY(HRDY), .FAULT_CLR(FAULT_CLR), .HENB(HENB), .HCFR(HCFR), .LCFR(LCFR),
    .GNT(GNT), .BUSY(BUSY),
`ifdef HOSC_STAT_CNT_EN
    .START_CNT(START_CNT), .FAIL_CNT(FAIL_CNT),
`endif
    .FAULT(FAULT));

`ifndef HOSC_STAT_CNT_EN
  assign START_CNT = 8'h00;
  assign FAIL_CNT  = 8'h00;
`endif

  always #5 LCLK = ~LCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_ARMING, M_SETTLING, M_BACKOFF, M_RUNNING, M_LINGER, M_FAULTED} mode_t;
  typedef struct {
    logic henb; logic [7:0] hcfr; logic [3:0] lcfr; logic [NREQ-1:0] gnt;
    logic busy; logic fault; logic [7:0] starts; logic [7:0] fails;
  } exp_t;

  exp_t  q[$];
  exp_t  m;
  mode_t mode = M_IDLE;
  int    attempts = 0, waited = 0, lingered = 0;
  logic  s1 = 1'b0, s2 = 1'b0;

  task automatic model_reset();
    mode = M_IDLE; attempts = 0; waited = 0; lingered = 0; s1 = 1'b0; s2 = 1'b0;
    m.henb = 0; m.hcfr = 0; m.lcfr = 0; m.gnt = 0; m.busy = 0; m.fault = 0;
    m.starts = 0; m.fails = 0;
  endtask

  initial model_reset();
  always @(negedge RST_N) model_reset();

  always @(posedge LCLK) begin
    if (!RST_N) begin
      model_reset();
    end else begin : step
      logic hs, any;
      logic [NREQ-1:0] g;
      hs = s2; s2 = s1; s1 = HRDY;
      any = |REQ; g = '0;
      case (mode)
        M_IDLE: if (any && !m.fault) begin
          mode = M_ARMING; m.hcfr = CFG_HCFR; attempts = 0;
          if (m.starts != 8'hFF) m.starts++;
        end
        M_ARMING: begin mode = M_SETTLING; waited = 0; end
        M_SETTLING:
          if (!any) mode = M_IDLE;
          else if (hs) mode = M_RUNNING;
          else if (waited == TMO_CYC - 1) begin
            if (attempts < RETRY) begin attempts++; mode = M_BACKOFF; end
            else mode = M_FAULTED;
            if (m.fails != 8'hFF) m.fails++;
          end else waited++;
        M_BACKOFF: mode = M_ARMING;
        M_RUNNING:
          if (!hs) begin mode = M_FAULTED; if (m.fails != 8'hFF) m.fails++; end
          else if (!any) begin mode = M_LINGER; lingered = 0; end
          else g = REQ;
        M_LINGER:
          if (!hs) begin mode = M_FAULTED; if (m.fails != 8'hFF) m.fails++; end
          else if (any) mode = M_RUNNING;
          else if (lingered == HOLD_CYC - 1) mode = M_IDLE;
          else lingered++;
        M_FAULTED: if (FAULT_CLR) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
      if (FAULT_CLR) begin m.starts = 0; m.fails = 0; end
      m.henb  = (mode == M_ARMING) || (mode == M_SETTLING) || (mode == M_RUNNING) || (mode == M_LINGER);
      m.busy  = (mode != M_IDLE);
      m.fault = (mode == M_FAULTED);
      m.gnt   = g;
      m.lcfr  = CFG_LCFR;
    end
    q.push_back(m);
  end

  // ---------------- monitor ----------------
  always @(negedge LCLK) begin
    if (q.size() > 0) begin : mon
      exp_t e;
      e = q.pop_front();
      check("sb_henb",  HENB,  e.henb);
      check("sb_hcfr",  HCFR,  e.hcfr);
      check("sb_lcfr",  LCFR,  e.lcfr);
      check("sb_gnt",   GNT,   e.gnt);
      check("sb_busy",  BUSY,  e.busy);
      check("sb_fault", FAULT, e.fault);
`ifdef HOSC_STAT_CNT_EN
      check("sb_start_cnt", START_CNT, e.starts);
      check("sb_fail_cnt",  FAIL_CNT,  e.fails);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge LCLK); #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_henb"}, HENB, 1'b0);
    check({nm, "_hcfr"}, HCFR, 8'h00);
    check({nm, "_lcfr"}, LCFR, 4'h0);
    check({nm, "_gnt"},  GNT, 3'b000);
    check({nm, "_busy"}, BUSY, 1'b0);
    check({nm, "_fault"}, FAULT, 1'b0);
    check({nm, "_start_cnt"}, START_CNT, 8'h00);
    check({nm, "_fail_cnt"},  FAIL_CNT, 8'h00);
  endtask

  task automatic async_reset(input string nm);
    @(negedge LCLK); #1;
    RST_N = 1'b0;
    #1 check_reset_outputs(nm);
    tick();
    RST_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int henb_hi, henb_lo, cyc;
    CFG_LCFR = 4'h9;
    tick();
    check_reset_outputs("reset");
    tick();
    RST_N = 1'b1;
    // Clean start with trim capture
    CFG_HCFR = 8'hA5; REQ = 3'b001;
    tick();                                   // edge 1
    check("s1_start_henb", HENB, 1'b1);
    check("s1_start_busy", BUSY, 1'b1);
    HRDY = 1'b1; CFG_HCFR = 8'h3C;
    tick(); tick(); tick();                   // edges 2..4
    check("s1_on_gnt0", GNT, 3'b000);
    tick();                                   // edge 5
    check("s1_gnt", GNT, 3'b001);
    check("s1_hcfr", HCFR, 8'hA5);
`ifdef HOSC_STAT_CNT_EN
    check("s1_start_cnt", START_CNT, 8'd1);
    check("s1_fail_cnt",  FAIL_CNT, 8'd0);
`endif
    REQ = 3'b101;
    tick();
    check("s2_gnt_add", GNT, 3'b101);
    REQ = 3'b000;
    tick();
    check("s2_drop_gnt", GNT, 3'b000);
    check("s2_hold_henb", HENB, 1'b1);
    tick(); tick(); tick();
    check("s2_hold_last_henb", HENB, 1'b1);
    tick();
    check("s2_off_henb", HENB, 1'b0);
    check("s2_off_busy", BUSY, 1'b0);
    // Reassert during hold: no re-wait
    REQ = 3'b001;
    repeat (4) tick();
    check("s3_gnt", GNT, 3'b001);
    REQ = 3'b000;
    tick(); tick();
    REQ = 3'b010;
    tick();
    check("s3_reon_henb", HENB, 1'b1);
    tick();
    check("s3_regrant", GNT, 3'b010);
    // HOSC loss while running
    REQ = 3'b011;
    tick();
    check("s4_gnt", GNT, 3'b011);
    HRDY = 1'b0;
    tick(); tick();
    check("s4_gnt_pre", GNT, 3'b011);
    tick();
    check("s4_fault", FAULT, 1'b1);
    check("s4_fault_gnt", GNT, 3'b000);
    check("s4_fault_henb", HENB, 1'b0);
    tick(); tick();
    check("s4_req_ignored", FAULT, 1'b1);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    check("s4_clr_fault", FAULT, 1'b0);
    check("s4_clr_busy", BUSY, 1'b0);
    tick();
    check("s4_restart_henb", HENB, 1'b1);
    // Timeout / retry with HRDY tied low
    henb_hi = 0; henb_lo = 0; cyc = 0;
    while (FAULT !== 1'b1 && cyc < 60) begin
      if (HENB === 1'b1) henb_hi++; else henb_lo++;
      tick(); cyc++;
    end
    check("s5_reached_fault", FAULT, 1'b1);
    check("s5_henb_hi_cycles", henb_hi, (RETRY + 1) * (TMO_CYC + 1));
    check("s5_henb_gaps", henb_lo, RETRY);
    check("s5_fault_henb", HENB, 1'b0);
    FAULT_CLR = 1'b1;
    tick();
    FAULT_CLR = 1'b0;
    tick();
    check("s5_start_after_clr", HENB, 1'b1);
    // Reset in the middle of WAIT
    tick();
    async_reset("s6_rst");
    HRDY = 1'b1;
    repeat (5) tick();
    check("s6_after_rst_gnt", GNT, 3'b011);
`ifdef HOSC_STAT_CNT_EN
    check("s6_start_cnt", START_CNT, 8'd1);
    check("s6_fail_cnt",  FAIL_CNT, 8'd0);
`endif
    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) REQ = NREQ'($urandom);
      if ($urandom_range(HRDY ? 40 : 6) == 0) HRDY = ~HRDY;
      FAULT_CLR = ($urandom_range(24) == 0);
      CFG_HCFR  = 8'($urandom);
      CFG_LCFR  = 4'($urandom);
      if ($urandom_range(400) == 0) async_reset("rnd_rst");
      else tick();
    end
    FAULT_CLR = 1'b0;
    tick(); tick();
    @(negedge LCLK); #1;
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
